// File: rtl/vco_spi_master_pkg.sv
// Shared types and constants for the VCO synthesizer SPI initiator.
// Serial-bus register map, control bits and FSM state type.
package vco_spi_master_pkg;

    localparam logic [6:0] VCO_DATA_ADDR = 7'd56;
    localparam logic [6:0] VCO_CTRL_ADDR = 7'd57;

    localparam int CTRL_CLR_OVF = 0;
    localparam int CTRL_FLUSH   = 1;

    localparam int WORD_BITS = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LATCH,
        ST_GAP
    } state_t;

    function automatic logic [31:0] pack_status(
        input logic       ovf,
        input logic [2:0] lvl,
        input logic       busy,
        input logic       lock
    );
        return {24'd0, ovf, lvl, 2'b00, busy, lock};
    endfunction

endpackage

// File: rtl/vco_spi_master_fifo.sv
// Pending-word buffer for the VCO SPI initiator.
// Push is accepted when not full or when a pop happens the same cycle; flush wins.
module vco_word_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop) && !flush;
    assign dout    = mem[rptr];

    // Storage array; contents need no reset, pointers define validity.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + LW'(1);
            end else if (do_pop && !do_push) begin
                level <= level - LW'(1);
            end
        end
    end

endmodule

// File: rtl/vco_spi_master.sv
// SPI initiator for the VCO/PLL synthesizer: buffers 32-bit words from the
// serial register bus and shifts each out MSB-first followed by an LE pulse.
module vco_spi_master
    import vco_spi_master_pkg::*;
#(
    parameter logic [6:0] DATA_ADDR  = VCO_DATA_ADDR,
    parameter logic [6:0] CTRL_ADDR  = VCO_CTRL_ADDR,
    parameter int         CLK_DIV    = 4,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        serial_strobe,
    input  logic [6:0]  serial_addr,
    input  logic [31:0] serial_data,
    input  logic        vco_muxout,
    output logic        vco_sclk,
    output logic        vco_sdata,
    output logic        vco_le,
    output logic        bus_req,
    output logic        busy,
    output logic [31:0] status
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    state_t              state;
    logic [31:0]         shreg;
    logic [4:0]          bit_cnt;
    logic [DW-1:0]       div;
    logic                phase_end;
    logic                push_req;
    logic                ctrl_req;
    logic                flush;
    logic                clr_ovf;
    logic                ovf_set;
    logic                pop;
    logic                overflow;
    logic                sync1;
    logic                lock;
    logic [31:0]         fifo_dout;
    logic [LW-1:0]       level;
    logic                full;
    logic                empty;

    assign push_req  = serial_strobe && (serial_addr == DATA_ADDR);
    assign ctrl_req  = serial_strobe && (serial_addr == CTRL_ADDR);
    assign flush     = ctrl_req && serial_data[CTRL_FLUSH];
    assign clr_ovf   = ctrl_req && serial_data[CTRL_CLR_OVF];
    assign phase_end = (div == DIV_LAST);
    assign pop       = !empty &&
                       ((state == ST_IDLE) ||
                        (state == ST_GAP && phase_end));
    assign ovf_set   = push_req && full && !pop;

    vco_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (WORD_BITS)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push_req),
        .pop     (pop),
        .flush   (flush),
        .din     (serial_data),
        .dout    (fifo_dout),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    assign busy   = (state != ST_IDLE) || (level != '0);
    assign status = pack_status(overflow, 3'(level), busy, lock);

    // Sticky overflow flag and lock-detect synchronizer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            sync1    <= 1'b0;
            lock     <= 1'b0;
        end else begin
            sync1 <= vco_muxout;
            lock  <= sync1;
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // Transfer FSM; pin registers take the value of the state being entered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            div       <= '0;
            vco_sclk  <= 1'b0;
            vco_sdata <= 1'b0;
            vco_le    <= 1'b0;
            bus_req   <= 1'b0;
        end else begin
            if (phase_end || state == ST_IDLE || state == ST_LOAD) begin
                div <= '0;
            end else begin
                div <= div + DW'(1);
            end
            unique case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state   <= ST_LOAD;
                        shreg   <= fifo_dout;
                        bus_req <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state     <= ST_SHIFT_LO;
                    bit_cnt   <= 5'd31;
                    vco_sclk  <= 1'b0;
                    vco_sdata <= shreg[31];
                end
                ST_SHIFT_LO: begin
                    if (phase_end) begin
                        state    <= ST_SHIFT_HI;
                        vco_sclk <= 1'b1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (phase_end) begin
                        vco_sclk <= 1'b0;
                        if (bit_cnt == 5'd0) begin
                            state     <= ST_LATCH;
                            vco_sdata <= 1'b0;
                            vco_le    <= 1'b1;
                        end else begin
                            state     <= ST_SHIFT_LO;
                            shreg     <= {shreg[30:0], 1'b0};
                            bit_cnt   <= bit_cnt - 5'd1;
                            vco_sdata <= shreg[30];
                        end
                    end
                end
                ST_LATCH: begin
                    if (phase_end) begin
                        state  <= ST_GAP;
                        vco_le <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (phase_end) begin
                        if (pop) begin
                            state <= ST_LOAD;
                            shreg <= fifo_dout;
                        end else begin
                            state   <= ST_IDLE;
                            bus_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
